// File: rtl/rpt_pkg.sv
// Shared definitions for the report-request issuer and the buffer-ID table it feeds.
package rpt_pkg;

   localparam int RPT_W    = 3;
   localparam int RES_W    = 3;
   localparam int NUM_SLOT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_t;

   // One table entry; the table stores {rpt_id, res_id}.
   typedef struct packed {
      logic [RPT_W-1:0] rpt_id;
      logic [RES_W-1:0] res_id;
   } entry_t;

endpackage

// File: rtl/rpt_req_issuer_chk.sv
// Occupancy invariants for rpt_req_issuer.
module rpt_req_issuer_chk #(
   parameter int NUM_SLOT = 8
) (
   input logic       clk,
   input logic       rst_n,
   input logic [3:0] busy_cnt,
   input logic       full
);

   a_busy_range: assert property (@(posedge clk) disable iff (!rst_n)
      busy_cnt <= 4'(NUM_SLOT));

   a_full_match: assert property (@(posedge clk) disable iff (!rst_n)
      full == (busy_cnt == 4'(NUM_SLOT)));

endmodule

// File: rtl/rr_free_find.sv
// Round-robin free-slot search: first zero bit of i_map at or above i_start, wrapping.
module rr_free_find #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] i_map,
   input  logic [W-1:0] i_start,
   output logic [W-1:0] o_idx,
   output logic         o_found
);

   // Walk offsets from farthest to nearest so the nearest free slot wins.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!i_map[i_start + W'(i)]) begin
            o_found = 1'b1;
            o_idx   = i_start + W'(i);
         end else begin
            o_found = o_found;
         end
      end
   end

endmodule

// File: rtl/rpt_req_issuer.sv
// Allocates report IDs round-robin for incoming requests and issues them to the buffer-ID table.
module rpt_req_issuer
   import rpt_pkg::*;
#(
   parameter int NUM_SLOT = rpt_pkg::NUM_SLOT,
   parameter int RPT_W    = rpt_pkg::RPT_W,
   parameter int RES_W    = rpt_pkg::RES_W,
   parameter int GAP_CYC  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_vld,
   input  logic [RES_W-1:0] req_res_id,
   output logic             req_rdy,
   output logic             pre_start,
   output logic [RPT_W-1:0] pre_rpt_id,
   output logic [RES_W-1:0] pre_res_id,
   input  logic             clear,
   input  logic [RPT_W-1:0] clr_rpt_id,
   output logic [3:0]       busy_cnt,
   output logic             full,
   output logic             err_clr
);

   state_t              r_state, w_state_nxt;
   logic [2:0]          r_gap_cnt, w_gap_nxt;
   logic [NUM_SLOT-1:0] r_out_map, w_map_nxt;
   logic [RPT_W-1:0]    r_rr_ptr, w_rr_nxt;
   logic                r_pre_start, w_start_nxt;
   logic [RPT_W-1:0]    r_pre_rpt_id, w_id_nxt;
   logic [RES_W-1:0]    r_pre_res_id, w_res_nxt;
   logic [3:0]          r_busy_cnt, w_busy_nxt;
   logic                r_full, r_err_clr;
   logic [RPT_W-1:0]    w_free_idx;
   logic                w_found, w_acc, w_clr_hit, w_clr_ok;

   rr_free_find #(.N(NUM_SLOT), .W(RPT_W)) u_find (
      .i_map   (r_out_map),
      .i_start (r_rr_ptr),
      .o_idx   (w_free_idx),
      .o_found (w_found)
   );

   assign req_rdy = (r_state == IDLE) && !r_full;
   assign w_acc   = req_vld && req_rdy && w_found;
   // The ID still waiting in ISSUE is not yet in the table, so releasing it is an error.
   assign w_clr_hit = r_out_map[clr_rpt_id] && !((r_state == ISSUE) && (clr_rpt_id == r_pre_rpt_id));
   assign w_clr_ok  = clear && w_clr_hit;

   // Next state and issue-interface values.
   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap_cnt;
      w_start_nxt = r_pre_start;
      w_id_nxt    = r_pre_rpt_id;
      w_res_nxt   = r_pre_res_id;
      w_rr_nxt    = r_rr_ptr;
      case (r_state)
         IDLE: begin
            if (w_acc) begin
               w_state_nxt = ISSUE;
               w_start_nxt = 1'b1;
               w_id_nxt    = w_free_idx;
               w_res_nxt   = req_res_id;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ISSUE: begin
            if (!clear) begin
               w_start_nxt = 1'b0;
               w_rr_nxt    = r_pre_rpt_id + {{(RPT_W-1){1'b0}}, 1'b1};
               if (GAP_CYC > 0) begin
                  w_state_nxt = GAP;
                  w_gap_nxt   = 3'(GAP_CYC - 1);
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_state_nxt = ISSUE;
            end
         end
         GAP: begin
            if (r_gap_cnt == 3'd0) begin
               w_state_nxt = IDLE;
            end else begin
               w_gap_nxt = r_gap_cnt - 3'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_start_nxt = 1'b0;
         end
      endcase
   end

   // Reservation bitmap and occupancy; a reservation and a release never touch the same bit.
   always_comb begin
      w_map_nxt  = r_out_map;
      w_busy_nxt = r_busy_cnt + {3'b000, w_acc} - {3'b000, w_clr_ok};
      if (w_acc) begin
         w_map_nxt[w_free_idx] = 1'b1;
      end else begin
         w_map_nxt = w_map_nxt;
      end
      if (w_clr_ok) begin
         w_map_nxt[clr_rpt_id] = 1'b0;
      end else begin
         w_map_nxt = w_map_nxt;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_gap_cnt <= 3'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_gap_cnt <= w_gap_nxt;
      end
   end

   // Datapath and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_map    <= '0;
         r_rr_ptr     <= '0;
         r_pre_start  <= 1'b0;
         r_pre_rpt_id <= '0;
         r_pre_res_id <= '0;
         r_busy_cnt   <= 4'd0;
         r_full       <= 1'b0;
         r_err_clr    <= 1'b0;
      end else begin
         r_out_map    <= w_map_nxt;
         r_rr_ptr     <= w_rr_nxt;
         r_pre_start  <= w_start_nxt;
         r_pre_rpt_id <= w_id_nxt;
         r_pre_res_id <= w_res_nxt;
         r_busy_cnt   <= w_busy_nxt;
         r_full       <= (w_busy_nxt == 4'(NUM_SLOT));
         r_err_clr    <= clear && !w_clr_hit;
      end
   end

   assign pre_start  = r_pre_start;
   assign pre_rpt_id = r_pre_rpt_id;
   assign pre_res_id = r_pre_res_id;
   assign busy_cnt   = r_busy_cnt;
   assign full       = r_full;
   assign err_clr    = r_err_clr;

   rpt_req_issuer_chk #(.NUM_SLOT(NUM_SLOT)) u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .busy_cnt (r_busy_cnt),
      .full     (r_full)
   );

endmodule

// File: tb/tb_rpt_req_issuer.sv
// Directed-vector bench for rpt_req_issuer with hand-computed expectations (GAP_CYC = 1).
module tb_rpt_req_issuer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_vld;
   logic [2:0] req_res_id;
   logic       req_rdy;
   logic       pre_start;
   logic [2:0] pre_rpt_id;
   logic [2:0] pre_res_id;
   logic       clear;
   logic [2:0] clr_rpt_id;
   logic [3:0] busy_cnt;
   logic       full;
   logic       err_clr;

   int n_vec = 0;
   int n_err = 0;

   rpt_req_issuer #(.NUM_SLOT(8), .RPT_W(3), .RES_W(3), .GAP_CYC(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_vld    (req_vld),
      .req_res_id (req_res_id),
      .req_rdy    (req_rdy),
      .pre_start  (pre_start),
      .pre_rpt_id (pre_rpt_id),
      .pre_res_id (pre_res_id),
      .clear      (clear),
      .clr_rpt_id (clr_rpt_id),
      .busy_cnt   (busy_cnt),
      .full       (full),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req_vld    = 1'b0;
      req_res_id = 3'd0;
      clear      = 1'b0;
      clr_rpt_id = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      chk("rst_pre_start", 32'(pre_start), 32'd0);
      chk("rst_pre_rpt_id", 32'(pre_rpt_id), 32'd0);
      chk("rst_pre_res_id", 32'(pre_res_id), 32'd0);
      chk("rst_busy", 32'(busy_cnt), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_err", 32'(err_clr), 32'd0);
      chk("rst_rdy", 32'(req_rdy), 32'd1);

      // First request: id 0 issued one cycle later, strobe drops the cycle after.
      req_vld = 1'b1; req_res_id = 3'd5;
      step();
      req_vld = 1'b0;
      chk("t1_start", 32'(pre_start), 32'd1);
      chk("t1_id", 32'(pre_rpt_id), 32'd0);
      chk("t1_res", 32'(pre_res_id), 32'd5);
      chk("t1_busy", 32'(busy_cnt), 32'd1);
      chk("t1_rdy_issue", 32'(req_rdy), 32'd0);
      step();
      chk("t1_start_drop", 32'(pre_start), 32'd0);
      chk("t1_rdy_gap", 32'(req_rdy), 32'd0);
      step();
      chk("t1_rdy_idle", 32'(req_rdy), 32'd1);

      // Eight back-to-back requests from a fresh reset fill the table, 3 cycles apart.
      do_reset();
      req_vld = 1'b1;
      for (int k = 0; k < 8; k++) begin
         req_res_id = 3'(k);
         chk("t2_rdy", 32'(req_rdy), 32'd1);
         step();
         chk("t2_start", 32'(pre_start), 32'd1);
         chk("t2_id", 32'(pre_rpt_id), 32'(k));
         chk("t2_busy", 32'(busy_cnt), 32'(k + 1));
         step();
         step();
      end
      chk("t2_full", 32'(full), 32'd1);
      chk("t2_rdy_full", 32'(req_rdy), 32'd0);
      repeat (3) step();
      chk("t2_stall_start", 32'(pre_start), 32'd0);
      chk("t2_stall_busy", 32'(busy_cnt), 32'd8);

      // Release id 3 while full; the stalled request then gets id 3.
      clear = 1'b1; clr_rpt_id = 3'd3;
      step();
      clear = 1'b0; req_res_id = 3'd2;
      chk("t3_busy", 32'(busy_cnt), 32'd7);
      chk("t3_full", 32'(full), 32'd0);
      chk("t3_rdy", 32'(req_rdy), 32'd1);
      chk("t3_noissue", 32'(pre_start), 32'd0);
      step();
      req_vld = 1'b0;
      chk("t3_id", 32'(pre_rpt_id), 32'd3);
      chk("t3_start", 32'(pre_start), 32'd1);
      chk("t3_busy_refill", 32'(busy_cnt), 32'd8);
      step();
      step();

      // Free id 2, reissue it, and hold clear for two cycles during ISSUE.
      clear = 1'b1; clr_rpt_id = 3'd2;
      step();
      chk("t4_busy_free", 32'(busy_cnt), 32'd7);
      clear = 1'b0; req_vld = 1'b1; req_res_id = 3'd4;
      step();
      req_vld = 1'b0;
      chk("t4_id", 32'(pre_rpt_id), 32'd2);
      chk("t4_start0", 32'(pre_start), 32'd1);
      clear = 1'b1; clr_rpt_id = 3'd2;
      for (int c = 0; c < 2; c++) begin
         step();
         chk("t4_start_hold", 32'(pre_start), 32'd1);
         chk("t4_id_hold", 32'(pre_rpt_id), 32'd2);
         chk("t4_res_hold", 32'(pre_res_id), 32'd4);
         chk("t4_busy_hold", 32'(busy_cnt), 32'd8);
         chk("t4_err_inissue", 32'(err_clr), 32'd1);
      end
      clear = 1'b0;
      step();
      chk("t4_start_drop", 32'(pre_start), 32'd0);
      chk("t4_err_drop", 32'(err_clr), 32'd0);
      chk("t4_busy_after", 32'(busy_cnt), 32'd8);
      step();

      // Release id 6, then release it again: second one is an error with no state change.
      clear = 1'b1; clr_rpt_id = 3'd6;
      step();
      chk("t5_busy_valid", 32'(busy_cnt), 32'd7);
      chk("t5_err_valid", 32'(err_clr), 32'd0);
      step();
      clear = 1'b0;
      chk("t5_err", 32'(err_clr), 32'd1);
      chk("t5_busy_err", 32'(busy_cnt), 32'd7);
      step();
      chk("t5_err_pulse", 32'(err_clr), 32'd0);
      chk("t5_busy_same", 32'(busy_cnt), 32'd7);
      req_vld = 1'b1; req_res_id = 3'd1;
      step();
      req_vld = 1'b0;
      chk("t5_realloc_id", 32'(pre_rpt_id), 32'd6);
      chk("t5_realloc_busy", 32'(busy_cnt), 32'd8);
      step();
      step();

      // Reset while in ISSUE drops the strobe at once and discards reservations.
      clear = 1'b1; clr_rpt_id = 3'd1;
      step();
      clear = 1'b0; req_vld = 1'b1; req_res_id = 3'd3;
      step();
      req_vld = 1'b0;
      chk("t6_id", 32'(pre_rpt_id), 32'd1);
      chk("t6_start", 32'(pre_start), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_start", 32'(pre_start), 32'd0);
      chk("t6_async_busy", 32'(busy_cnt), 32'd0);
      chk("t6_async_full", 32'(full), 32'd0);
      step();
      rst_n = 1'b1;
      req_vld = 1'b1; req_res_id = 3'd7;
      step();
      req_vld = 1'b0;
      chk("t6_first_id", 32'(pre_rpt_id), 32'd0);
      chk("t6_first_res", 32'(pre_res_id), 32'd7);
      chk("t6_first_busy", 32'(busy_cnt), 32'd1);
      step();
      step();

      // Reservation and valid release in the same cycle leave the count unchanged.
      req_vld = 1'b1; req_res_id = 3'd2; clear = 1'b1; clr_rpt_id = 3'd0;
      step();
      req_vld = 1'b0; clear = 1'b0;
      chk("t7_id", 32'(pre_rpt_id), 32'd1);
      chk("t7_busy", 32'(busy_cnt), 32'd1);
      chk("t7_err", 32'(err_clr), 32'd0);
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
